mux_2a1_intercalador: RTL
=========================

Name: mux_2a1_intercalador

Overview:
- Transmit-side counterpart of the 1:2 byte demux.
- Takes two 8-bit lanes, each with its own valid. Both lanes are sampled together once every two clk8f cycles.
- Emits one interleaved byte stream at one byte per clk8f cycle: lane 0 first, then lane 1. Each output byte carries a lane tag.
- Sits between the per-lane byte sources and the parallel-to-serial stage, so the demux at the far end can recover both lanes.

Parameters:
- DATA_W, 8, width of each lane and of the output byte.
- IDLE_BYTE, 8'h00, value driven on data_out_c when the emitted slot is not valid.
- CNT_W, 16, width of the saturating count of valid bytes transmitted.

Ports:
- clk8f  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in_0_c  in  DATA_W  lane 0 byte.
- valid_in_0_c  in  1  lane 0 byte valid.
- data_in_1_c  in  DATA_W  lane 1 byte.
- valid_in_1_c  in  1  lane 1 byte valid.
- data_out_c  out  DATA_W  interleaved output byte.
- valid_out_c  out  1  output byte valid.
- lane_out_c  out  1  lane tag of the current output byte (0 = lane 0, 1 = lane 1).
- phase_c  out  1  current slot phase; 0 means the next edge samples the inputs.
- tx_count_c  out  CNT_W  saturating count of valid bytes emitted.

Behaviour:
- Interface: one clock, clk8f; reset is synchronous and active-high, sampled only on the rising edge of clk8f.
- Reset (any edge with reset=1, including mid-stream):
  - phase_c=0, hold registers and their valids cleared.
  - data_out_c=IDLE_BYTE, valid_out_c=0, lane_out_c=0, tx_count_c=0.
  - No partially emitted pair survives reset.
- The first edge with reset=0 is a phase-0 edge.
- Phase: 1-bit register, toggles on every non-reset edge.
- Edge with phase_c=0 (sample edge):
  - hold1 <= data_in_1_c, hv1 <= valid_in_1_c.
  - Output register <= lane 0 directly: data_out_c = valid_in_0_c ? data_in_0_c : IDLE_BYTE; valid_out_c = valid_in_0_c; lane_out_c = 0.
  - Lane 0 latency is 1 cycle from its sample edge.
- Edge with phase_c=1 (flush edge):
  - data_out_c = hv1 ? hold1 : IDLE_BYTE; valid_out_c = hv1; lane_out_c = 1.
  - Lane 1 latency is 2 cycles from its sample edge.
- Inputs are sampled only on phase-0 edges. Changes on phase-1 edges are ignored, so sources hold each byte for two cycles.
- Invalid slots always carry IDLE_BYTE. Input data is never passed through when its valid=0.
- Lanes are independent: either, both or neither may be valid in a pair. Slot order is fixed; no slot is skipped or compacted.
- tx_count_c increments by 1 on every edge that loads valid_out_c=1. It saturates at all-ones and never wraps.
- Output is fully registered; no combinational path from inputs to outputs.
- Steady-state throughput: 2 lane bytes per 2 cycles.
- The block has no backpressure. The downstream stage consumes one byte every cycle.

Decomposition:
- Package mux_pkg holds:
  - LANE0=1'b0 and LANE1=1'b1.
  - The default IDLE_BYTE.
  - A typedef for the byte+valid+lane slot bundle, shared with the demux.
- One natural sub-module: contador_sat, the parameterised saturating counter with synchronous clear, used for tx_count_c.
- Phase register and hold register stay inline.

Test Plan:
- Reset, then one cycle later: reset=1 held 4 cycles with inputs 0x11/0xFF, both valids 0 → data_out_c=0x00, valid_out_c=0 and tx_count_c=0 throughout; first post-release edge has phase_c=0.
- Both lanes valid, 0x1B / 0xF5, held 2 cycles from a phase-0 edge → output sequence 0x1B (lane 0, valid) then 0xF5 (lane 1, valid); tx_count_c +2.
- Lane 0 only valid, 0x13 / 0xFD → 0x13 (valid, lane 0) then 0x00 (invalid, lane 1); 0xFD never appears; tx_count_c +1.
- Lane 1 only valid, 0x17 / 0xF9, plus a lane 1 change to 0xAA on the phase-1 edge → 0x00 invalid, then 0xF9 valid; 0xAA ignored.
- Mid-stream reset asserted on a phase-1 edge while 0xED is held → next output is IDLE invalid; 0xED is dropped; phase_c=0 after release.
- CNT_W=4 with 20 consecutive valid bytes → tx_count_c reaches 4'hF and stays there.

Source files
------------

// File: rtl/mux_2a1_intercalador_pkg.sv
// Shared definitions for the 2:1 byte interleaver and its 1:2 demux counterpart.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: lane tag constants, default idle byte, and the byte+valid+lane slot bundle.
package mux_pkg;

    // Lane tags carried alongside each interleaved byte.
    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int         BYTE_W            = 8;
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

    // One interleaved slot as seen on the link: byte, its valid, and its lane tag.
    typedef struct packed {
        logic [BYTE_W-1:0] dat;
        logic              vld;
        logic              lane;
    } slot_t;

endpackage

// File: rtl/mux_2a1_intercalador_if.sv
// Bundle of the lane inputs and interleaved outputs of mux_2a1_intercalador.
// Latency: n/a (wiring only).
// Backpressure: none; the downstream stage takes one byte every clk8f cycle.
//
// master: byte sources / observer side (drives lane inputs, reads outputs).
// slave : interleaver side (reads lane inputs, drives outputs).
interface mux_2a1_intercalador_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] data_in_0_c;
    logic              valid_in_0_c;
    logic [DATA_W-1:0] data_in_1_c;
    logic              valid_in_1_c;
    logic [DATA_W-1:0] data_out_c;
    logic              valid_out_c;
    logic              lane_out_c;
    logic              phase_c;
    logic [CNT_W-1:0]  tx_count_c;

    modport master (
        output data_in_0_c, valid_in_0_c, data_in_1_c, valid_in_1_c,
        input  data_out_c, valid_out_c, lane_out_c, phase_c, tx_count_c
    );

    modport slave (
        input  data_in_0_c, valid_in_0_c, data_in_1_c, valid_in_1_c,
        output data_out_c, valid_out_c, lane_out_c, phase_c, tx_count_c
    );
endinterface

// File: rtl/mux_2a1_intercalador_contador_sat.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects an increment one clock after inc is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk (clock), clr (sync clear, active-high), inc (count enable), count (W-bit value).
module contador_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mux_2a1_intercalador.sv
// Interleaves two byte lanes into one tagged byte stream, lane 0 then lane 1.
// Latency: lane 0 byte 1 cycle after its sample edge, lane 1 byte 2 cycles after.
// Backpressure: none; downstream must accept one byte every clk8f cycle.
//
// Ports: clk8f (clock), reset (sync, active-high), bus (slave modport: two lanes in,
// interleaved byte/valid/lane tag out, slot phase, saturating count of valid bytes sent).
module mux_2a1_intercalador
    import mux_pkg::*;
#(
    parameter int                DATA_W    = BYTE_W,
    parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(IDLE_BYTE_DEFAULT),
    parameter int                CNT_W     = 16
) (
    input  logic                      clk8f,
    input  logic                      reset,
    mux_2a1_intercalador_if.slave     bus
);

    // Slot phase: sample edge loads lane 0 and captures lane 1; flush edge emits lane 1.
    localparam logic [0:0] PH_SAMPLE = 1'b0;
    localparam logic [0:0] PH_FLUSH  = 1'b1;

    logic [0:0]        phase;
    logic [DATA_W-1:0] hold1;
    logic              hv1;
    logic [DATA_W-1:0] out_dat;
    logic              out_vld;
    logic              out_lane;
    logic              nxt_vld;

    always_ff @(posedge clk8f) begin
        if (reset) begin
            phase    <= PH_SAMPLE;
            hold1    <= '0;
            hv1      <= 1'b0;
            out_dat  <= IDLE_BYTE;
            out_vld  <= 1'b0;
            out_lane <= LANE0;
        end else begin
            phase <= ~phase;
            if (phase == PH_SAMPLE) begin
                // Lane 1 waits one cycle in the hold register while lane 0 goes out.
                hold1    <= bus.data_in_1_c;
                hv1      <= bus.valid_in_1_c;
                out_dat  <= bus.valid_in_0_c ? bus.data_in_0_c : IDLE_BYTE;
                out_vld  <= bus.valid_in_0_c;
                out_lane <= LANE0;
            end else begin
                // Inputs are ignored here; sources hold each byte for two cycles.
                out_dat  <= hv1 ? hold1 : IDLE_BYTE;
                out_vld  <= hv1;
                out_lane <= LANE1;
            end
        end
    end

    // Valid about to be loaded into the output register; drives the byte counter
    // so the count moves on the same edge the valid byte appears.
    assign nxt_vld = (phase == PH_FLUSH) ? hv1 : bus.valid_in_0_c;

    contador_sat #(
        .W (CNT_W)
    ) u_tx_cnt (
        .clk   (clk8f),
        .clr   (reset),
        .inc   (nxt_vld),
        .count (bus.tx_count_c)
    );

    assign bus.data_out_c  = out_dat;
    assign bus.valid_out_c = out_vld;
    assign bus.lane_out_c  = out_lane;
    assign bus.phase_c     = phase;

endmodule
